// File: rtl/ncl_th_gate_sequencer.sv
// ncl_th_gate_sequencer
//
// Clocked stimulus/check controller for a single NCL threshold gate (THmn
// family). For every non-NULL input pattern (1 .. 2^N_IN-1, ascending) it
// drives a NULL wavefront, waits for the gate output to reset, then drives
// the DATA wavefront and waits for the output to reach the expected
// threshold value (popcount(pattern) >= THRESH). Each phase waits at most
// TIMEOUT cycles. A NULL timeout records a failure and skips that pattern's
// DATA phase. A DATA phase either passes or times out.
//
// Optional feature (compile-time macro SEQ_STOP_ON_FAIL_EN):
//   defined   - the first recorded failure ends the sweep immediately (DONE)
//   undefined - the sweep always covers every pattern
//
// Parameters:
//   N_IN    - number of gate inputs (2..4)
//   THRESH  - gate threshold m
//   TIMEOUT - max cycles per phase waiting for the expected output (>= 1)
//
// Ports:
//   clk            in   sole clock, rising edge
//   rst            in   synchronous active-high reset
//   start          in   begin a sweep (sampled in IDLE or DONE only)
//   y              in   output of the gate-under-test
//   gate_in        out  gate inputs (bit 0 = a, bit 1 = b, ...)
//   busy           out  high while a NULL or DATA phase is in progress
//   done           out  high in DONE
//   vec_idx        out  current pattern
//   pass_cnt       out  patterns passed
//   fail_cnt       out  patterns failed
//   first_fail_idx out  pattern of the first failure, 0 if none
//
// All outputs come straight from flops; y only reaches next-state logic.

module ncl_th_gate_sequencer #(
    parameter int N_IN    = 3,
    parameter int THRESH  = 1,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            y,
    output logic [N_IN-1:0] gate_in,
    output logic            busy,
    output logic            done,
    output logic [N_IN-1:0] vec_idx,
    output logic [N_IN:0]   pass_cnt,
    output logic [N_IN:0]   fail_cnt,
    output logic [N_IN-1:0] first_fail_idx
);

    // Timer only has to reach TIMEOUT-1.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [N_IN-1:0] LAST_PAT  = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] FIRST_PAT = N_IN'(1);
    localparam logic [TW-1:0]   TMR_LAST  = TW'(TIMEOUT - 1);
    localparam logic [N_IN:0]   THRESH_W  = (N_IN + 1)'(THRESH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        NULL_PH = 2'd1,
        DATA_PH = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Number of asserted rails in a pattern.
    function automatic logic [N_IN:0] popcount(input logic [N_IN-1:0] v);
        logic [N_IN:0] cnt;
        cnt = {(N_IN + 1){1'b0}};
        for (int i = 0; i < N_IN; i++) begin
            cnt = cnt + {{N_IN{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    state_t          state_r, state_s;
    logic [N_IN-1:0] gate_r, gate_s;
    logic [N_IN-1:0] vec_r, vec_s;
    logic [N_IN:0]   pass_r, pass_s;
    logic [N_IN:0]   fail_r, fail_s;
    logic [N_IN-1:0] ffi_r, ffi_s;
    logic [TW-1:0]   timer_r, timer_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;

    logic            y_exp_s;
    logic            timer_exp_s;
    logic            fail_ev_s;
    logic            adv_s;

    // Next-state, counter and wavefront computation.
    always_comb begin
        state_s     = state_r;
        gate_s      = gate_r;
        vec_s       = vec_r;
        pass_s      = pass_r;
        fail_s      = fail_r;
        ffi_s       = ffi_r;
        timer_s     = timer_r;
        fail_ev_s   = 1'b0;
        adv_s       = 1'b0;
        y_exp_s     = 1'b0;
        timer_exp_s = (timer_r == TMR_LAST);

        if (state_r == DATA_PH) begin
            y_exp_s = (popcount(vec_r) >= THRESH_W);
        end else begin
            y_exp_s = 1'b0;
        end

        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    pass_s  = {(N_IN + 1){1'b0}};
                    fail_s  = {(N_IN + 1){1'b0}};
                    ffi_s   = {N_IN{1'b0}};
                    vec_s   = FIRST_PAT;
                    gate_s  = {N_IN{1'b0}};
                    timer_s = {TW{1'b0}};
                    state_s = NULL_PH;
                end else begin
                    state_s = state_r;
                end
            end
            NULL_PH: begin
                if (y == 1'b0) begin
                    gate_s  = vec_r;
                    timer_s = {TW{1'b0}};
                    state_s = DATA_PH;
                end else if (timer_exp_s) begin
                    // Gate never reset: count a failure, skip its DATA phase.
                    fail_ev_s = 1'b1;
                    adv_s     = 1'b1;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            DATA_PH: begin
                if (y == y_exp_s) begin
                    pass_s = pass_r + (N_IN + 1)'(1);
                    adv_s  = 1'b1;
                end else if (timer_exp_s) begin
                    fail_ev_s = 1'b1;
                    adv_s     = 1'b1;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                gate_s  = {N_IN{1'b0}};
            end
        endcase

        if (fail_ev_s) begin
            fail_s = fail_r + (N_IN + 1)'(1);
            if (fail_r == {(N_IN + 1){1'b0}}) begin
                ffi_s = vec_r;
            end else begin
                ffi_s = ffi_r;
            end
        end else begin
            fail_s = fail_s;
        end

        if (adv_s) begin
            gate_s = {N_IN{1'b0}};
            if (vec_r == LAST_PAT) begin
                state_s = DONE;
            end else begin
                vec_s   = vec_r + N_IN'(1);
                timer_s = {TW{1'b0}};
                state_s = NULL_PH;
            end
        end else begin
            vec_s = vec_s;
        end

`ifdef SEQ_STOP_ON_FAIL_EN
        // First failure ends the sweep; remaining patterns are not driven.
        if (fail_ev_s) begin
            state_s = DONE;
            gate_s  = {N_IN{1'b0}};
            vec_s   = vec_r;
        end else begin
            state_s = state_s;
        end
`endif

        busy_s = (state_s == NULL_PH) || (state_s == DATA_PH);
        done_s = (state_s == DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            gate_r  <= {N_IN{1'b0}};
            vec_r   <= {N_IN{1'b0}};
            pass_r  <= {(N_IN + 1){1'b0}};
            fail_r  <= {(N_IN + 1){1'b0}};
            ffi_r   <= {N_IN{1'b0}};
            timer_r <= {TW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            gate_r  <= gate_s;
            vec_r   <= vec_s;
            pass_r  <= pass_s;
            fail_r  <= fail_s;
            ffi_r   <= ffi_s;
            timer_r <= timer_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign gate_in        = gate_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign vec_idx        = vec_r;
    assign pass_cnt       = pass_r;
    assign fail_cnt       = fail_r;
    assign first_fail_idx = ffi_r;

endmodule

// File: tb/tb_ncl_th_gate_sequencer.sv
// Bench for ncl_th_gate_sequencer. Two instances share clk/rst/start:
//   u1: THRESH=1 driving an ideal 1-of-3 gate (optionally stuck at 1)
//   u2: THRESH=2 driving an ideal 1-of-3 gate (patterns 1,2,4 must fail)

module tb_ncl_th_gate_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic stuck;

    logic [2:0] g1, g2, v1, v2, f1, f2;
    logic [3:0] p1, p2, fc1, fc2;
    logic       b1, b2, d1, d2, y1, y2;

    always #5 clk = ~clk;

    // Zero-delay gate models.
    assign y1 = stuck ? 1'b1 : (|g1);
    assign y2 = |g2;

    ncl_th_gate_sequencer #(.N_IN(3), .THRESH(1), .TIMEOUT(15)) u1 (
        .clk(clk), .rst(rst), .start(start), .y(y1),
        .gate_in(g1), .busy(b1), .done(d1), .vec_idx(v1),
        .pass_cnt(p1), .fail_cnt(fc1), .first_fail_idx(f1)
    );

    ncl_th_gate_sequencer #(.N_IN(3), .THRESH(2), .TIMEOUT(15)) u2 (
        .clk(clk), .rst(rst), .start(start), .y(y2),
        .gate_in(g2), .busy(b2), .done(d2), .vec_idx(v2),
        .pass_cnt(p2), .fail_cnt(fc2), .first_fail_idx(f2)
    );

`ifdef SEQ_STOP_ON_FAIL_EN
    localparam int A2_CYC = 17, A2_PASS = 0, A2_FAIL = 1, A2_VEC = 1;
    localparam int B_CYC  = 16, B_FAIL  = 1, B_VEC   = 1;
`else
    localparam int A2_CYC = 57, A2_PASS = 4, A2_FAIL = 3, A2_VEC = 7;
    localparam int B_CYC  = 106, B_FAIL = 7, B_VEC   = 7;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [2:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called right after the start edge: checks u1's NULL/DATA wavefronts
    // cycle by cycle against a scoreboard, then the DONE result.
    task automatic run_sweep(input string tag);
        logic [2:0] e;
        for (int p = 1; p <= 7; p++) begin
            exp_q.push_back(3'd0);
            exp_q.push_back(3'(p));
        end
        for (int i = 0; i < 14; i++) begin
            e = exp_q.pop_front();
            check({tag, "_busy"}, 32'(b1), 32'd1);
            check({tag, "_gate"}, 32'(g1), 32'(e));
            tick();
        end
        check({tag, "_done"}, 32'(d1), 32'd1);
        check({tag, "_busy_end"}, 32'(b1), 32'd0);
        check({tag, "_gate_end"}, 32'(g1), 32'd0);
        check({tag, "_pass"}, 32'(p1), 32'd7);
        check({tag, "_fail"}, 32'(fc1), 32'd0);
        check({tag, "_ffi"}, 32'(f1), 32'd0);
        check({tag, "_vec"}, 32'(v1), 32'd7);
    endtask

    initial begin
        int cyc;
        logic nz;
        rst   = 1'b1;
        start = 1'b0;
        stuck = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        check("rst_gate", 32'(g1), 32'd0);
        check("rst_busy", 32'(b1), 32'd0);
        check("rst_done", 32'(d1), 32'd0);
        check("rst_vec", 32'(v1), 32'd0);
        check("rst_pass", 32'(p1), 32'd0);
        check("rst_fail", 32'(fc1), 32'd0);
        check("rst_ffi", 32'(f1), 32'd0);
        check("rst_busy2", 32'(b2), 32'd0);
        check("rst_done2", 32'(d2), 32'd0);

        // A: ideal sweep on u1, THRESH=2 sweep on u2.
        start = 1'b1;
        tick();
        start = 1'b0;
        run_sweep("A");
        cyc = 15;
        while (!d2 && cyc < 400) begin
            tick();
            cyc++;
        end
        check("A2_cycles", 32'(cyc), 32'(A2_CYC));
        check("A2_pass", 32'(p2), 32'(A2_PASS));
        check("A2_fail", 32'(fc2), 32'(A2_FAIL));
        check("A2_ffi", 32'(f2), 32'd1);
        check("A2_vec", 32'(v2), 32'(A2_VEC));
        check("A2_busy", 32'(b2), 32'd0);

        // B: gate stuck at 1 -> every NULL phase times out.
        stuck = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        nz  = 1'b0;
        while (!d1 && cyc < 400) begin
            if (g1 != 3'd0) nz = 1'b1;
            tick();
            cyc++;
        end
        check("B_cycles", 32'(cyc), 32'(B_CYC));
        check("B_data_driven", 32'(nz), 32'd0);
        check("B_fail", 32'(fc1), 32'(B_FAIL));
        check("B_pass", 32'(p1), 32'd0);
        check("B_ffi", 32'(f1), 32'd1);
        check("B_vec", 32'(v1), 32'(B_VEC));
        stuck = 1'b0;
        cyc = 0;
        while (!d2 && cyc < 400) begin
            tick();
            cyc++;
        end

        // C: reset in pattern 4 DATA phase, then a fresh sweep.
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!(v1 == 3'd4 && g1 == 3'd4) && cyc < 100) begin
            tick();
            cyc++;
        end
        check("C_reach", 32'(cyc), 32'd8);
        check("C_pass_pre", 32'(p1), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("C_busy", 32'(b1), 32'd0);
        check("C_done", 32'(d1), 32'd0);
        check("C_gate", 32'(g1), 32'd0);
        check("C_vec", 32'(v1), 32'd0);
        check("C_pass", 32'(p1), 32'd0);
        check("C_fail", 32'(fc1), 32'd0);
        check("C_busy2", 32'(b2), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_sweep("C2");

        // D: start held high; only DONE restarts, and restart clears.
        start = 1'b1;
        tick();
        run_sweep("D1");
        tick();
        check("D_restart_busy", 32'(b1), 32'd1);
        check("D_restart_done", 32'(d1), 32'd0);
        check("D_restart_pass", 32'(p1), 32'd0);
        check("D_restart_fail", 32'(fc1), 32'd0);
        check("D_restart_vec", 32'(v1), 32'd1);
        start = 1'b0;
        run_sweep("D2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
